booth_mult_pipe: RTL



---
 rtl/booth_mult_pipe.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/booth_mult_pipe.sv
// Pipelined radix-4 Booth multiplier, 4 register stages, valid/ready with full backpressure.
// Optional MAC_ACC_EN adds an accEn input and a running accumulator folded into the final add.
module booth_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic                 signedFlag,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [TAG_W-1:0]     inTag,
`ifdef MAC_ACC_EN
    input  logic                 accEn,
`endif
    output logic                 outValid,
    input  logic                 outReady,
    output logic [2*WIDTH-1:0]   out,
    output logic [TAG_W-1:0]     outTag
);

    localparam int PW  = 2 * WIDTH;
    localparam int NPP = WIDTH / 2 + 1;
    localparam int N0  = NPP + 1;
    localparam int N1  = 2 * (N0 / 4) + (N0 % 4);
    localparam int N2  = 2 * (N1 / 4) + (N1 % 4);
    localparam logic [PW-1:0] ONE = 1;

    function automatic logic signed [WIDTH+1:0] booth_pp(input logic [2:0] grp,
                                                        input logic signed [WIDTH:0] a);
        logic signed [WIDTH+1:0] a1;
        a1 = {a[WIDTH], a};
        case (grp)
            3'b001, 3'b010: booth_pp = a1;
            3'b011:         booth_pp = a1 <<< 1;
            3'b100:         booth_pp = -(a1 <<< 1);
            3'b101, 3'b110: booth_pp = -a1;
            default:        booth_pp = '0;
        endcase
    endfunction

    // Returns {carry, sum}; the carry row is already shifted into place.
    function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x,
                                            input logic [PW-1:0] y,
                                            input logic [PW-1:0] z);
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        csa = {c, s};
    endfunction

    logic                   rdy0, rdy1, rdy2, rdy3;
    logic                   ld0, ld1, ld2, ld3;
    logic                   vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q;
    logic                   ext_b;
    logic [WIDTH+2:0]       bx;
    logic signed [WIDTH:0]  ax;
    logic [PW-1:0]          row_p0_d [N1];
    logic [PW-1:0]          row_p0_q [N1];
    logic [PW-1:0]          row_p1_d [N2];
    logic [PW-1:0]          row_p1_q [N2];
    logic [PW-1:0]          sum_p2_d, carry_p2_d, sum_p2_q, carry_p2_q;
    logic [PW-1:0]          prod_d, out_q;
    logic [TAG_W-1:0]       tag_p0_q, tag_p1_q, tag_p2_q, tag_p3_q;
`ifdef MAC_ACC_EN
    logic                   acc_en_p0_q, acc_en_p1_q, acc_en_p2_q;
    logic [PW-1:0]          acc_q;
`endif

    // A stage may load when it is empty or its occupant leaves this cycle.
    assign rdy3 = !vld_p3_q || outReady;
    assign rdy2 = !vld_p2_q || rdy3;
    assign rdy1 = !vld_p1_q || rdy2;
    assign rdy0 = !vld_p0_q || rdy1;
    assign ld0  = rdy0 && inValid;
    assign ld1  = rdy1 && vld_p0_q;
    assign ld2  = rdy2 && vld_p1_q;
    assign ld3  = rdy3 && vld_p2_q;

    assign inReady  = rdy0;
    assign outValid = vld_p3_q;
    assign out      = out_q;
    assign outTag   = tag_p3_q;

    assign ext_b = signedFlag & multiplier[WIDTH-1];
    assign bx    = {ext_b, ext_b, multiplier, 1'b0};
    assign ax    = {signedFlag & multiplicand[WIDTH-1], multiplicand};

    // ---- S0: Booth partial products, sign-compressed rows, first 4:2 level
    always_comb begin : s0_comb
        logic [PW-1:0]           rows0 [N0];
        logic [PW-1:0]           cst, s_a, c_a, s_b, c_b;
        logic signed [WIDTH+1:0] pp;
        cst = '0; s_a = '0; c_a = '0; s_b = '0; c_b = '0; pp = '0;
        for (int i = 0; i < N0; i++) rows0[i] = '0;
        for (int i = 0; i < N1; i++) row_p0_d[i] = '0;
        for (int i = 0; i < NPP; i++) begin
            pp       = booth_pp(bx[2*i +: 3], ax);
            rows0[i] = PW'({~pp[WIDTH+1], pp[WIDTH:0]}) << (2 * i);
            if (WIDTH + 1 + 2 * i < PW) cst = cst - (ONE << (WIDTH + 1 + 2 * i));
        end
        rows0[NPP] = cst;
        for (int g = 0; g < N0 / 4; g++) begin
            {c_a, s_a} = csa(rows0[4*g], rows0[4*g+1], rows0[4*g+2]);
            {c_b, s_b} = csa(s_a, c_a, rows0[4*g+3]);
            row_p0_d[2*g]   = s_b;
            row_p0_d[2*g+1] = c_b;
        end
        for (int k = 0; k < N0 % 4; k++) row_p0_d[2*(N0/4)+k] = rows0[4*(N0/4)+k];
    end

    // ---- S1: second 4:2 level
    always_comb begin : s1_comb
        logic [PW-1:0] s_a, c_a, s_b, c_b;
        s_a = '0; c_a = '0; s_b = '0; c_b = '0;
        for (int i = 0; i < N2; i++) row_p1_d[i] = '0;
        for (int g = 0; g < N1 / 4; g++) begin
            {c_a, s_a} = csa(row_p0_q[4*g], row_p0_q[4*g+1], row_p0_q[4*g+2]);
            {c_b, s_b} = csa(s_a, c_a, row_p0_q[4*g+3]);
            row_p1_d[2*g]   = s_b;
            row_p1_d[2*g+1] = c_b;
        end
        for (int k = 0; k < N1 % 4; k++) row_p1_d[2*(N1/4)+k] = row_p0_q[4*(N1/4)+k];
    end

    // ---- S2: remaining rows folded down to one sum and one carry row
    always_comb begin : s2_comb
        logic [PW-1:0] s, c;
        s = row_p1_q[0];
        c = row_p1_q[1];
        for (int k = 2; k < N2; k++) {c, s} = csa(s, c, row_p1_q[k]);
        sum_p2_d   = s;
        carry_p2_d = c;
    end

    // ---- S3: final carry-propagate add; the accumulator joins as a third row
    always_comb begin : s3_comb
`ifdef MAC_ACC_EN
        logic [PW-1:0] acc_row, s, c;
        acc_row = acc_en_p2_q ? acc_q : '0;
        {c, s}  = csa(sum_p2_q, carry_p2_q, acc_row);
        prod_d  = s + c;
`else
        prod_d  = sum_p2_q + carry_p2_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            out_q    <= '0;
            tag_p3_q <= '0;
`ifdef MAC_ACC_EN
            acc_q    <= '0;
`endif
        end else begin
            if (rdy0) vld_p0_q <= inValid;
            if (rdy1) vld_p1_q <= vld_p0_q;
            if (rdy2) vld_p2_q <= vld_p1_q;
            if (rdy3) vld_p3_q <= vld_p2_q;
            if (ld3) begin
                out_q    <= prod_d;
                tag_p3_q <= tag_p2_q;
`ifdef MAC_ACC_EN
                acc_q    <= prod_d;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld0) begin
            row_p0_q <= row_p0_d;
            tag_p0_q <= inTag;
`ifdef MAC_ACC_EN
            acc_en_p0_q <= accEn;
`endif
        end
        if (ld1) begin
            row_p1_q <= row_p1_d;
            tag_p1_q <= tag_p0_q;
`ifdef MAC_ACC_EN
            acc_en_p1_q <= acc_en_p0_q;
`endif
        end
        if (ld2) begin
            sum_p2_q   <= sum_p2_d;
            carry_p2_q <= carry_p2_d;
            tag_p2_q   <= tag_p1_q;
`ifdef MAC_ACC_EN
            acc_en_p2_q <= acc_en_p1_q;
`endif
        end
    end

endmodule
